// File: rtl/time_tracking_queue.sv
// FIFO that stamps each entry on push and reports its queued cycle count on pop.
// Optional same-cycle empty-queue pass-through is enabled by defining TTQ_BYPASS_EN.
module time_tracking_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               push,
    input  logic               pop,
    input  logic signed [63:0] data,
    output logic               push_valid,
    output logic               pop_valid,
    output logic signed [63:0] out,
    output logic signed [63:0] waited
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [63:0]   mem_data  [DEPTH];
    logic [63:0]   mem_stamp [DEPTH];
    logic [63:0]   now;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          is_empty;
    logic          is_full;
    logic          pop_ok;
    logic          push_ok;
    logic          bypass;
    logic          store;

    assign is_empty = (count == '0);
    assign is_full  = (count == CW'(DEPTH));
    assign pop_ok   = pop && !is_empty;

`ifdef TTQ_BYPASS_EN
    assign bypass = push && pop && is_empty;
`else
    assign bypass = 1'b0;
`endif

    // A pop frees a slot before the same-cycle push is judged.
    assign push_ok = push && (!is_full || pop_ok);
    assign store   = push_ok && !bypass;

    always_ff @(posedge clk) begin
        if (!rst) begin
            now        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_valid <= 1'b0;
            pop_valid  <= 1'b0;
            out        <= '0;
            waited     <= '0;
        end else if (en) begin
            now        <= now + 64'd1;
            push_valid <= push_ok;
            pop_valid  <= pop_ok || bypass;
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                out    <= mem_data[rd_ptr];
                waited <= now - mem_stamp[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end else if (bypass) begin
                out    <= data;
                waited <= '0;
            end
            unique case ({store, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end else begin
            push_valid <= 1'b0;
            pop_valid  <= 1'b0;
        end
    end

    // Storage needs no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (rst && en && store) begin
            mem_data[wr_ptr]  <= data;
            mem_stamp[wr_ptr] <= now;
        end
    end

endmodule

// File: tb/tb_time_tracking_queue.sv
// Directed scoreboard bench for time_tracking_queue.
// Expected results come from a small FIFO/time model in the bench.
module tb_time_tracking_queue;

    logic               clk;
    logic               rst;
    logic               en;
    logic               push;
    logic               pop;
    logic signed [63:0] data;
    logic               push_valid;
    logic               pop_valid;
    logic signed [63:0] out_w;
    logic signed [63:0] waited;

    time_tracking_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .push      (push),
        .pop       (pop),
        .data      (data),
        .push_valid(push_valid),
        .pop_valid (pop_valid),
        .out       (out_w),
        .waited    (waited)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [63:0] s;
    } ent_t;

    typedef struct packed {
        logic        pv;
        logic        qv;
        logic [63:0] o;
        logic [63:0] w;
    } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    logic [63:0] tnow;
    logic [63:0] m_out;
    logic [63:0] m_wait;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset(input int n);
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        en   = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
        mq.delete();
        sb.delete();
        tnow   = '0;
        m_out  = '0;
        m_wait = '0;
        chk("rst_push_valid", {63'd0, push_valid}, 64'd0);
        chk("rst_pop_valid", {63'd0, pop_valid}, 64'd0);
        chk("rst_out", out_w, 64'd0);
        chk("rst_waited", waited, 64'd0);
    endtask

    task automatic step(input logic p, input logic q,
                        input logic [63:0] d, input logic e);
        exp_t rec;
        logic pop_acc;
        logic push_acc;
        logic byp;
        push = p;
        pop  = q;
        data = d;
        en   = e;
        pop_acc = e && q && (mq.size() > 0);
`ifdef TTQ_BYPASS_EN
        byp = e && p && q && (mq.size() == 0);
`else
        byp = 1'b0;
`endif
        push_acc = e && p && ((mq.size() < 4) || pop_acc);
        if (pop_acc) begin
            m_out  = mq[0].d;
            m_wait = tnow - mq[0].s;
            void'(mq.pop_front());
        end else if (byp) begin
            m_out  = d;
            m_wait = '0;
        end
        if (push_acc && !byp) mq.push_back({d, tnow});
        if (e) tnow = tnow + 64'd1;
        rec = '{pv: push_acc, qv: pop_acc || byp, o: m_out, w: m_wait};
        sb.push_back(rec);
        @(posedge clk);
        #1;
        rec = sb.pop_front();
        chk("push_valid", {63'd0, push_valid}, {63'd0, rec.pv});
        chk("pop_valid", {63'd0, pop_valid}, {63'd0, rec.qv});
        chk("out", out_w, rec.o);
        chk("waited", waited, rec.w);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b0;
        en   = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        data = '0;
        tnow = '0;

        do_reset(3);
        step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("pop_no_push", {63'd0, pop_valid}, 64'd0);

        // wait measurement: fresh timeline starting at edge 0
        do_reset(1);
        for (int k = 0; k < 8; k++)
            step(k % 2 == 0, 1'b0, 64'(k / 2 + 1), 1'b1);
        step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("wm_out", out_w, 64'd1);
        chk("wm_waited", waited, 64'd8);
        repeat (3) step(1'b0, 1'b0, 64'd0, 1'b1);
        step(1'b1, 1'b0, 64'd5, 1'b1);
        chk("wm_push5", {63'd0, push_valid}, 64'd1);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("wm_out2", out_w, 64'd2);
        chk("wm_waited2", waited, 64'd12);
        repeat (4) step(1'b0, 1'b1, 64'd0, 1'b1);

        // full
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 64'(10 + k), 1'b1);
        step(1'b1, 1'b0, 64'd9, 1'b1);
        chk("full_push_rej", {63'd0, push_valid}, 64'd0);
        step(1'b1, 1'b1, 64'd9, 1'b1);
        chk("full_pp_push", {63'd0, push_valid}, 64'd1);
        chk("full_pp_out", out_w, 64'd10);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("full_last", out_w, 64'd9);

        // empty
        step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("empty_pop_rej", {63'd0, pop_valid}, 64'd0);
        chk("empty_out_hold", out_w, 64'd9);
        step(1'b1, 1'b1, 64'd7, 1'b1);
`ifdef TTQ_BYPASS_EN
        chk("byp_out", out_w, 64'd7);
        chk("byp_waited", waited, 64'd0);
        step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("byp_count0", {63'd0, pop_valid}, 64'd0);
`else
        chk("nobyp_pop_rej", {63'd0, pop_valid}, 64'd0);
        step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("nobyp_count1", {63'd0, pop_valid}, 64'd1);
        chk("nobyp_out", out_w, 64'd7);
`endif

        // enable
        step(1'b1, 1'b0, 64'd3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 64'd99, 1'b0);
            chk("en_no_pv", {63'd0, push_valid}, 64'd0);
            chk("en_no_qv", {63'd0, pop_valid}, 64'd0);
        end
        step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("en_out", out_w, 64'd3);
        chk("en_waited", waited, 64'd1);

        // wrap-around with irregular gaps
        for (int k = 0; k < 10; k++) begin
            step(1'b1, k >= 2, 64'(100 + k), 1'b1);
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 64'd0, 1'b1);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 64'd0, 1'b1);
        step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("wrap_last", out_w, 64'd109);

        // reset mid-operation discards contents
        step(1'b1, 1'b0, 64'd55, 1'b1);
        step(1'b1, 1'b0, 64'd56, 1'b1);
        do_reset(1);
        step(1'b0, 1'b1, 64'd0, 1'b1);
        chk("rst_discard", {63'd0, pop_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
